// File: rtl/regfile_pkg.sv
// Shared constants, width helper and word/index types for the multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    function automatic int addr_w(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    localparam int AW_DEF = addr_w(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] word_t;

endpackage

// File: rtl/reg_file_rdport.sv
// One registered read port: zero-register check, optional write forwarding, output flops.
// Forwarding is compiled in only when REGFILE_BYPASS_EN is defined.
module reg_file_rdport
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    localparam int AW   = addr_w(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [AW-1:0]         addr,
    input  logic [NREGS*XLEN-1:0] regs_flat,
    input  logic [NREGS-1:0]      busy_q,
    input  logic [NREGS-1:0]      busy_d,
    input  logic [1:0]            wr_en,
    input  logic [2*AW-1:0]       wr_addr,
    input  logic [2*XLEN-1:0]     wr_data,
    output logic [XLEN-1:0]       rd_data,
    output logic                  rd_busy
);

    logic [XLEN-1:0] data_d;
    logic            busy_nxt;

    always_comb begin
        data_d   = '0;
        busy_nxt = 1'b0;
        if (addr != '0) begin
            data_d   = regs_flat[int'(addr)*XLEN +: XLEN];
            busy_nxt = busy_q[addr];
        end
`ifdef REGFILE_BYPASS_EN
        // wr_en arrives already qualified (nonzero address, lane-0 conflict loss removed)
        if (wr_en[1] && wr_addr[AW +: AW] == addr) begin
            data_d = wr_data[XLEN +: XLEN];
        end else if (wr_en[0] && wr_addr[0 +: AW] == addr) begin
            data_d = wr_data[0 +: XLEN];
        end
        busy_nxt = busy_d[addr];
`endif
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{busy_d, wr_en, wr_addr, wr_data};
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else begin
            rd_data <= data_d;
            rd_busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with two prioritised write lanes and a pending-write scoreboard.
// Optional same-cycle write-to-read forwarding via REGFILE_BYPASS_EN.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF,
    localparam int AW   = addr_w(NREGS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [1:0]          wr_en,
    input  logic [2*AW-1:0]     wr_addr,
    input  logic [2*XLEN-1:0]   wr_data,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr
);

    logic [XLEN-1:0]       regs_q [NREGS];
    logic [NREGS*XLEN-1:0] regs_flat;
    logic [NREGS-1:0]      busy_q, busy_d;
    logic [AW-1:0]         wa0, wa1;
    logic                  wr0_ok, wr1_ok;

    assign wa0 = wr_addr[0 +: AW];
    assign wa1 = wr_addr[AW +: AW];

    // Lane 1 wins a same-address conflict, so lane 0 is simply dropped
    assign wr1_ok = wr_en[1] && (wa1 != '0);
    assign wr0_ok = wr_en[0] && (wa0 != '0) && !(wr_en[1] && wa1 == wa0);

    always_comb begin
        busy_d = busy_q;
        if (wr0_ok) busy_d[wa0] = 1'b0;
        if (wr1_ok) busy_d[wa1] = 1'b0;
        if (sb_set && sb_addr != '0) busy_d[sb_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            if (wr0_ok) regs_q[wa0] <= wr_data[0 +: XLEN];
            if (wr1_ok) regs_q[wa1] <= wr_data[XLEN +: XLEN];
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREGS; i++) regs_flat[i*XLEN +: XLEN] = regs_q[i];
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        reg_file_rdport #(
            .XLEN  (XLEN),
            .NREGS (NREGS)
        ) u_rdport (
            .clock     (clock),
            .reset     (reset),
            .addr      (rd_addr[k*AW +: AW]),
            .regs_flat (regs_flat),
            .busy_q    (busy_q),
            .busy_d    (busy_d),
            .wr_en     ({wr1_ok, wr0_ok}),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .rd_data   (rd_data[k*XLEN +: XLEN]),
            .rd_busy   (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: directed vectors plus random traffic against a reference model.
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [1:0]          wr_en = '0;
    logic [2*AW-1:0]     wr_addr = '0;
    logic [2*XLEN-1:0]   wr_data = '0;
    logic                sb_set = 1'b0;
    logic [AW-1:0]       sb_addr = '0;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clock   (clock),
        .reset   (reset),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_busy (rd_busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .sb_set  (sb_set),
        .sb_addr (sb_addr)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          tag;
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mregs [NREGS];
    logic        mbusy [NREGS];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents fresh read results for the entries tagged with it
    always @(negedge clock) begin
        while (sb_q.size() > 0 && sb_q[0].tag <= cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            if (e.tag < cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL stale_entry port %0d: tag %0d seen at cycle %0d", e.port, e.tag, cyc);
            end else begin
                check($sformatf("rd_data[%0d]", e.port), rd_data[e.port*XLEN +: XLEN], e.data);
                check($sformatf("rd_busy[%0d]", e.port), {31'd0, rd_busy[e.port]}, {31'd0, e.busy});
            end
        end
    end

    task automatic push_exp(input int port, input logic [31:0] d, input logic b);
        exp_t e;
        e.tag = cyc + 1; e.port = port; e.data = d; e.busy = b;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] we, input int a0, input logic [31:0] d0,
                         input int a1, input logic [31:0] d1, input logic sbs, input int sba,
                         input int r0, input int r1);
        wr_en   = we;
        wr_addr = {AW'(a1), AW'(a0)};
        wr_data = {d1, d0};
        sb_set  = sbs;
        sb_addr = AW'(sba);
        rd_addr = {AW'(r1), AW'(r0)};
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREGS; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    // Applies current inputs to the model, optionally queues model-derived expectations, then clocks
    task automatic issue(input bit use_model);
        logic [31:0] nregs [NREGS];
        logic        nbusy [NREGS];
        int a, a0, a1;
        a0 = int'(wr_addr[0 +: AW]);
        a1 = int'(wr_addr[AW +: AW]);
        for (int i = 0; i < NREGS; i++) begin
            nregs[i] = mregs[i];
            nbusy[i] = mbusy[i];
        end
        if (wr_en[0] && a0 != 0) begin nregs[a0] = wr_data[0 +: XLEN]; nbusy[a0] = 1'b0; end
        if (wr_en[1] && a1 != 0) begin nregs[a1] = wr_data[XLEN +: XLEN]; nbusy[a1] = 1'b0; end
        if (sb_set && sb_addr != 0) nbusy[int'(sb_addr)] = 1'b1;
        if (use_model) begin
            for (int k = 0; k < NRD; k++) begin
                a = int'(rd_addr[k*AW +: AW]);
`ifdef REGFILE_BYPASS_EN
                push_exp(k, nregs[a], nbusy[a]);
`else
                push_exp(k, mregs[a], mbusy[a]);
`endif
            end
        end
        for (int i = 0; i < NREGS; i++) begin
            mregs[i] = nregs[i];
            mbusy[i] = nbusy[i];
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_zero_outputs(input string tagname);
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("%s_data[%0d]", tagname, k), rd_data[k*XLEN +: XLEN], 32'h0);
            check($sformatf("%s_busy[%0d]", tagname, k), {31'd0, rd_busy[k]}, 32'h0);
        end
    endtask

    initial begin
        model_clear();
        #12;
        check_zero_outputs("por");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        // Register 0: write and reservation both ignored
        drive(2'b01, 0, 32'hFFFF_FFFF, 0, 0, 1'b1, 0, 0, 0);
        push_exp(0, 32'h0, 1'b0); push_exp(1, 32'h0, 1'b0);
        issue(0);
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
        push_exp(0, 32'h0, 1'b0); push_exp(1, 32'h0, 1'b0);
        issue(0);

        // Lane conflict on reg3: lane 1 data wins
        drive(2'b11, 3, 32'h11, 3, 32'h22, 1'b0, 0, 3, 3);
`ifdef REGFILE_BYPASS_EN
        push_exp(0, 32'h22, 1'b0); push_exp(1, 32'h22, 1'b0);
`else
        push_exp(0, 32'h0, 1'b0);  push_exp(1, 32'h0, 1'b0);
`endif
        issue(0);
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 3, 3);
        push_exp(0, 32'h22, 1'b0); push_exp(1, 32'h22, 1'b0);
        issue(0);

        // Scoreboard on reg7
        drive(2'b00, 0, 0, 0, 0, 1'b1, 7, 7, 0);
`ifdef REGFILE_BYPASS_EN
        push_exp(0, 32'h0, 1'b1);
`else
        push_exp(0, 32'h0, 1'b0);
`endif
        issue(0);
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 7, 0);
        push_exp(0, 32'h0, 1'b1);
        issue(0);
        drive(2'b01, 7, 32'h77, 0, 0, 1'b1, 7, 7, 0);
`ifdef REGFILE_BYPASS_EN
        push_exp(0, 32'h77, 1'b1);
`else
        push_exp(0, 32'h0, 1'b1);
`endif
        issue(0);
        drive(2'b10, 0, 0, 7, 32'h78, 1'b0, 0, 7, 0);
`ifdef REGFILE_BYPASS_EN
        push_exp(0, 32'h78, 1'b0);
`else
        push_exp(0, 32'h77, 1'b1);
`endif
        issue(0);
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 7, 0);
        push_exp(0, 32'h78, 1'b0);
        issue(0);

        // Same-edge write/read of reg9
        drive(2'b01, 9, 32'hA, 0, 0, 1'b0, 0, 0, 0);
        issue(0);
        drive(2'b01, 9, 32'hB, 0, 0, 1'b0, 0, 9, 9);
`ifdef REGFILE_BYPASS_EN
        push_exp(0, 32'hB, 1'b0); push_exp(1, 32'hB, 1'b0);
`else
        push_exp(0, 32'hA, 1'b0); push_exp(1, 32'hA, 1'b0);
`endif
        issue(0);
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 9);
        push_exp(0, 32'hB, 1'b0); push_exp(1, 32'hB, 1'b0);
        issue(0);

        // All ports on reg4
        drive(2'b10, 0, 0, 4, 32'h44, 1'b0, 0, 0, 0);
        issue(0);
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 4, 4);
        push_exp(0, 32'h44, 1'b0); push_exp(1, 32'h44, 1'b0);
        issue(0);

        // Reset mid-operation with reg5 written and reserved
        drive(2'b01, 5, 32'hDEAD_BEEF, 0, 0, 1'b0, 0, 0, 0);
        issue(0);
        drive(2'b00, 0, 0, 0, 0, 1'b1, 5, 5, 5);
        issue(0);
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5, 5);
        push_exp(0, 32'hDEAD_BEEF, 1'b1); push_exp(1, 32'hDEAD_BEEF, 1'b1);
        issue(0);
        issue(0);
        @(negedge clock);
        #1 reset = 1'b1;
        #1 check_zero_outputs("rst");
        drive(2'b11, 5, 32'h1234, 6, 32'h5678, 1'b1, 5, 5, 6);
        model_clear();
        @(posedge clock); #1;
        check_zero_outputs("rst_hold");
        @(negedge clock);
        reset = 1'b0;
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 5, 6);
        @(posedge clock); #1;
        push_exp(0, 32'h0, 1'b0); push_exp(1, 32'h0, 1'b0);
        issue(0);

        // Random traffic against the reference model
        for (int n = 0; n < 10000; n++) begin
            drive(2'($urandom_range(0, 3)),
                  int'($urandom_range(0, NREGS-1)), $urandom,
                  int'($urandom_range(0, NREGS-1)), $urandom,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, NREGS-1)),
                  int'($urandom_range(0, NREGS-1)), int'($urandom_range(0, NREGS-1)));
            issue(1);
        end

        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
